// File: rtl/pipelined_adder_if.sv
// Handshake bundle for pipelined_adder: an operand stream in and a result stream out.
// A transfer happens on a rising edge where valid && ready; a valid producer holds its data until that edge.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output in_valid, in1, in2, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry
  );

  modport slave (
    input  in_valid, in1, in2, carry_in, out_ready,
    output in_ready, out_valid, sum, carry
  );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined unsigned adder: one CW-bit chunk per stage, carry registered between stages,
// with a collapsing valid/ready pipeline (empty stages always refill, full blocked stages hold).
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic             clk,
  input logic             rst_n,
  pipelined_adder_if.slave bus
);
  localparam int CW = (STAGES > 0) ? WIDTH / STAGES : 1;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES must lie in 1..WIDTH");
  end

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] c_w;
  logic [STAGES-1:0] load;
  logic [WIDTH-1:0]  sum_w [STAGES];
  logic [WIDTH-1:0]  a_w   [STAGES];
  logic [WIDTH-1:0]  b_w   [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_src, b_src, s_src, s_nxt;
    logic             c_src, v_src;
    logic [CW:0]      chunk;
    logic             v_q, c_q;
    logic [WIDTH-1:0] s_q, a_q, b_q;

    if (k == 0) begin : g_head
      assign a_src = bus.in1;
      assign b_src = bus.in2;
      assign s_src = '0;
      assign c_src = bus.carry_in;
      assign v_src = bus.in_valid;
    end else begin : g_body
      assign a_src = a_w[k-1];
      assign b_src = b_w[k-1];
      assign s_src = sum_w[k-1];
      assign c_src = c_w[k-1];
      assign v_src = v[k-1];
    end

    // A stage can move unless it and every stage after it is full and the sink stalls.
    assign load[k] = bus.out_ready | ~(&v[STAGES-1:k]);

    assign chunk = {1'b0, a_src[k*CW +: CW]} + {1'b0, b_src[k*CW +: CW]} + {{CW{1'b0}}, c_src};

    always_comb begin
      s_nxt              = s_src;
      s_nxt[k*CW +: CW]  = chunk[CW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
        a_q <= '0;
        b_q <= '0;
      end else if (load[k]) begin
        v_q <= v_src;
        // Data only moves with a real operation; bubbles leave the old contents in place.
        if (v_src) begin
          c_q <= chunk[CW];
          s_q <= s_nxt;
          a_q <= a_src;
          b_q <= b_src;
        end
      end
    end

    assign v[k]     = v_q;
    assign c_w[k]   = c_q;
    assign sum_w[k] = s_q;
    assign a_w[k]   = a_q;
    assign b_w[k]   = b_q;
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = v[STAGES-1];
  assign bus.sum       = sum_w[STAGES-1];
  assign bus.carry     = c_w[STAGES-1];
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=8, STAGES=2): directed scenarios plus a random stream
// checked against plain 9-bit arithmetic.
module tb_pipelined_adder;
  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   ready_mode;   // 0: out_ready=1, 1: random, 2: held by main sequence
  int   seen_valid;
  logic [WIDTH:0] exp_q[$];

  pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // sink pacing
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) seen_valid++;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result actual=0x%0h expected=none", {bus.carry, bus.sum});
      end else begin
        check("result", {23'd0, bus.carry, bus.sum}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  // driver: call just after a rising edge; returns cycles spent waiting for in_ready
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                      output int waits);
    logic [WIDTH:0] model;
    waits = 0;
    bus.in1 = a;
    bus.in2 = b;
    bus.carry_in = c;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        model = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        break;
      end
      waits++;
      if (waits > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout actual=%0d expected<=200", waits);
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int w;
    int sum_w;
    logic [WIDTH:0] held;
    total = 0;
    bad = 0;
    seen_valid = 0;
    ready_mode = 2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in1 = '0;
    bus.in2 = '0;
    bus.carry_in = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    #3;
    check("in_ready_in_reset", bus.in_ready, 1);
    check("out_valid_in_reset", bus.out_valid, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_sum", bus.sum, 0);
    check("reset_carry", bus.carry, 0);
    check("reset_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    ready_mode = 0;
    bus.out_ready = 1'b1;

    // basic add with latency and single-cycle out_valid
    send(8'h12, 8'h34, 1'b0, w);
    @(negedge clk);
    check("basic_not_yet_valid", bus.out_valid, 0);
    @(negedge clk);
    check("basic_valid", bus.out_valid, 1);
    check("basic_sum", bus.sum, 8'h46);
    @(negedge clk);
    check("basic_valid_one_cycle", bus.out_valid, 0);
    @(posedge clk);
    #1;
    drain("basic_drain");

    // full carry ripple
    send(8'hFF, 8'h00, 1'b1, w);
    send(8'hFF, 8'hFF, 1'b1, w);
    drain("ripple_drain");

    // back-to-back stream at full throughput
    sum_w = 0;
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 8'(8'h10 * i), 1'b0, w);
      sum_w += w;
    end
    check("stream_no_stall", sum_w, 0);
    repeat (STAGES) @(posedge clk);
    #1;
    check("stream_drained_in_latency", exp_q.size(), 0);

    // backpressure: fill, hold, release
    ready_mode = 2;
    bus.out_ready = 1'b0;
    send(8'h01, 8'h01, 1'b0, w);
    send(8'h02, 8'h02, 1'b0, w);
    @(negedge clk);
    held = {bus.carry, bus.sum};
    check("bp_out_valid", bus.out_valid, 1);
    check("bp_sum", bus.sum, 8'h02);
    check("bp_in_ready", bus.in_ready, 0);
    repeat (3) @(negedge clk);
    check("bp_hold_stable", {bus.carry, bus.sum}, held);
    check("bp_hold_valid", bus.out_valid, 1);
    @(posedge clk);
    #1;
    ready_mode = 0;
    bus.out_ready = 1'b1;
    drain("bp_drain");

    // bubble collapse: second op enters while the first waits at the output
    ready_mode = 2;
    bus.out_ready = 1'b0;
    send(8'h80, 8'h80, 1'b0, w);
    idle(3);
    send(8'h01, 8'h00, 1'b0, w);
    check("bubble_accept_waits", w, 0);
    idle(2);
    ready_mode = 0;
    bus.out_ready = 1'b1;
    drain("bubble_drain");

    // reset with two operations in flight
    ready_mode = 2;
    bus.out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b0, w);
    send(8'h33, 8'h44, 1'b1, w);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid_async", bus.out_valid, 0);
    check("rst_sum_async", bus.sum, 0);
    check("rst_carry_async", bus.carry, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    bus.out_ready = 1'b1;
    seen_valid = 0;
    repeat (5) @(negedge clk);
    check("rst_no_stale_result", seen_valid, 0);
    check("rst_in_ready_after", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // randomized stream with random backpressure and input gaps
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    ready_mode = 0;
    drain("random_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
